alu_seq: RTL

Multi-cycle, parametrised successor to the combinational 4-function ALU. It latches operands on a `start` handshake and computes the result:
- add and subtract in one cycle;
- multiply with an iterative shift-add datapath;
- divide with an iterative restoring datapath.

It replaces the wide combinational multiplier/divider with a WIDTH-cycle sequencer, so the block closes timing at larger WIDTH. It sits between the operand registers and the result bus, and reports completion with a one-cycle `done` pulse.

---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq request/result bundle.
// Master drives start/operands, slave returns status and result.
interface alu_seq_if #(
  parameter int WIDTH = 6
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [1:0]         func;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] out;
  logic               ovf;
  logic               dbz;

  modport master (
    output start, a, b, func,
    input  busy, done, out, ovf, dbz
  );

  modport slave (
    input  start, a, b, func,
    output busy, done, out, ovf, dbz
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: 1-cycle add/sub, WIDTH-cycle shift-add mul and restoring div.
// Optional macro ALU_SEQ_DBZ_EN adds early divide-by-zero completion and dbz flag.
module alu_seq #(
  parameter int WIDTH = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [1:0]         r_func;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_pend;
  logic [2*WIDTH-1:0] r_out;
  logic               r_ovf;
  logic               r_done;

  logic               w_acc, w_z, w_last, w_fin;
  logic [WIDTH:0]     w_as, w_msum, w_shf;
  logic [WIDTH-1:0]   w_dif;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_mstep, w_dstep;

  assign w_acc = bus.start && (r_state == IDLE);

`ifdef ALU_SEQ_DBZ_EN
  assign w_z = (bus.func == 2'b11) && (bus.b == '0);
`else
  assign w_z = 1'b0;
`endif

  assign w_last = (r_state != IDLE) && (r_cnt == CW'(WIDTH));
  assign w_fin  = r_pend || w_last;

  assign w_as = r_func[0] ? ({1'b0, r_a} - {1'b0, r_b})
                          : ({1'b0, r_a} + {1'b0, r_b});

  // product reg: {partial sum, unconsumed multiplier bits}
  assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mstep = {w_msum, r_acc[WIDTH-1:1]};

  // divide reg: {partial remainder, dividend/quotient bits}
  assign w_shf   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge    = w_shf >= {1'b0, r_b};
  assign w_dif   = w_shf[WIDTH-1:0] - r_b;
  assign w_dstep = w_ge
    ? {w_dif, r_acc[WIDTH-2:0], 1'b1}
    : {w_shf[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state: dispatch on accept, leave after WIDTH iterations
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_acc && bus.func == 2'b10)
          w_next = MUL;
        else if (w_acc && bus.func == 2'b11 && !w_z)
          w_next = DIV;
      end
      MUL, DIV: begin
        if (w_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // operand latch, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_func <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_pend <= 1'b0;
      r_out  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fin;
      r_pend <= w_acc && (!bus.func[1] || w_z);
      if (w_acc) begin
        r_a    <= bus.a;
        r_b    <= bus.b;
        r_func <= bus.func;
        r_cnt  <= '0;
        r_acc  <= bus.func[0] ? {{WIDTH{1'b0}}, bus.a}
                              : {{WIDTH{1'b0}}, bus.b};
      end else if (r_state == MUL && !w_last) begin
        r_acc <= w_mstep;
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == DIV && !w_last) begin
        r_acc <= w_dstep;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_pend) begin
        if (r_func[1]) begin
          r_out <= {{WIDTH{1'b1}}, r_a};
          r_ovf <= 1'b0;
        end else begin
          r_out <= {{WIDTH{1'b0}}, w_as[WIDTH-1:0]};
          r_ovf <= w_as[WIDTH];
        end
      end else if (w_last) begin
        r_ovf <= 1'b0;
        r_out <= (r_state == MUL) ? r_acc
               : {r_acc[WIDTH-1:0], r_acc[2*WIDTH-1:WIDTH]};
      end
    end
  end

`ifdef ALU_SEQ_DBZ_EN
  logic r_dbz;

  // dbz set by early div-by-zero completion, cleared by any other
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_dbz <= 1'b0;
    else if (w_fin) r_dbz <= r_pend && r_func[1];
  end

  assign bus.dbz = r_dbz;
`else
  assign bus.dbz = 1'b0;
`endif

  assign bus.busy = (r_state != IDLE) && (r_cnt != '0);
  assign bus.done = r_done;
  assign bus.out  = r_out;
  assign bus.ovf  = r_ovf;
endmodule
